// File: rtl/vga_fpga_pkg.sv
// Shared definitions for the iCEstick VGA wrapper: sequencer states,
// default timing constants and a counter-width helper.
package vga_fpga_pkg;

  localparam int CLK_HZ      = 25_175_000;
  localparam int DEBOUNCE_MS = 10;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_DEBOUNCE_CYCLES  = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_POR_HOLD_CYCLES  = 1024;
  localparam int DEF_MIN_RESET_CYCLES = 16;

  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_RUN     = 2'd1,
    S_BTN     = 2'd2,
    S_STRETCH = 2'd3
  } seq_state_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser plus level debouncer. A new level is accepted only
// after it has been seen on every one of DEBOUNCE_CYCLES consecutive samples.
module btn_debounce
  import vga_fpga_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_raw,
  output logic btn_stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_sync;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign btn_sync   = sync_q[SYNC_STAGES-1];
  assign btn_stable = stable_q;

  // Shift the asynchronous button level through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_n_raw};
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (btn_sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = btn_sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser, accepted level and debounce counter; released button is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_reset_sequencer.sv
// Generates the active-low VGA core reset from PLL lock and the board button:
// power-on hold, debounced button reset with minimum-width stretch, status LED
// and a press counter for bring-up.
module btn_reset_sequencer
  import vga_fpga_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int POR_HOLD_CYCLES  = DEF_POR_HOLD_CYCLES,
  parameter int MIN_RESET_CYCLES = DEF_MIN_RESET_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n_raw,
  output logic       rst_n_out,
  output logic       led_active,
  output logic       btn_event,
  output logic [7:0] press_count
);

  localparam int HW = cnt_width(POR_HOLD_CYCLES);
  localparam int SW = cnt_width(MIN_RESET_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(POR_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(MIN_RESET_CYCLES - 1);

  logic          btn_stable;
  seq_state_t    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;
  logic [7:0]    press_cnt_q, press_cnt_d;
  logic          rst_n_q, rst_n_d;
  logic          led_q, led_d;
  logic          event_q, event_d;
  logic          press_fire;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_n_raw  (btn_n_raw),
    .btn_stable (btn_stable)
  );

  assign rst_n_out   = rst_n_q;
  assign led_active  = led_q;
  assign btn_event   = event_q;
  assign press_count = press_cnt_q;

  // State, counters and outputs all move together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_POR;
      hold_cnt_q    <= '0;
      stretch_cnt_q <= '0;
      press_cnt_q   <= '0;
      rst_n_q       <= 1'b0;
      led_q         <= 1'b0;
      event_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      press_cnt_q   <= press_cnt_d;
      rst_n_q       <= rst_n_d;
      led_q         <= led_d;
      event_q       <= event_d;
    end
  end

  // Next state: power-on hold, then follow the debounced button with a stretch on release.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    stretch_cnt_d = stretch_cnt_q;
    press_fire    = 1'b0;
    case (state_q)
      S_POR: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = btn_stable ? S_RUN : S_BTN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_RUN: begin
        if (!btn_stable) begin
          state_d    = S_BTN;
          press_fire = 1'b1;
        end
      end
      S_BTN: begin
        if (btn_stable) begin
          state_d       = S_STRETCH;
          stretch_cnt_d = '0;
        end
      end
      S_STRETCH: begin
        if (!btn_stable) begin
          state_d       = S_BTN;
          stretch_cnt_d = '0;
        end else if (stretch_cnt_q == STRETCH_LAST) begin
          state_d       = S_RUN;
          stretch_cnt_d = '0;
        end else begin
          stretch_cnt_d = stretch_cnt_q + SW'(1);
        end
      end
      default: begin
        state_d = S_POR;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    rst_n_d     = (state_d == S_RUN);
    led_d       = (state_d == S_RUN);
    event_d     = press_fire;
    press_cnt_d = press_fire ? (press_cnt_q + 8'd1) : press_cnt_q;
  end

endmodule

// File: tb/tb_btn_reset_sequencer.sv
// Bench for btn_reset_sequencer: directed button sequences on a main instance
// and a fast-debounce instance, checked every cycle against a timing model.
module tb_btn_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int DEB    = 8;
  localparam int POR    = 16;
  localparam int MINR   = 4;
  localparam int F_DEB  = 2;
  localparam int F_MINR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n_raw = 1'b1;
  logic       btn2_n_raw = 1'b1;
  logic       rst_n_out, led_active, btn_event;
  logic [7:0] press_count;
  logic       rst2_n_out, led2_active, btn2_event;
  logic [7:0] press2_count;

  int total = 0;
  int bad   = 0;

  btn_reset_sequencer #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .POR_HOLD_CYCLES  (POR),
    .MIN_RESET_CYCLES (MINR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n_raw   (btn_n_raw),
    .rst_n_out   (rst_n_out),
    .led_active  (led_active),
    .btn_event   (btn_event),
    .press_count (press_count)
  );

  btn_reset_sequencer #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (F_DEB),
    .POR_HOLD_CYCLES  (POR),
    .MIN_RESET_CYCLES (F_MINR)
  ) dut_fast (
    .clk         (clk),
    .rst         (rst),
    .btn_n_raw   (btn2_n_raw),
    .rst_n_out   (rst2_n_out),
    .led_active  (led2_active),
    .btn_event   (btn2_event),
    .press_count (press2_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    int         n;
    logic [31:0] raw_h;
    logic [31:0] sync_h;
    logic       stable;
    int         last_low;
    bit         has_low;
    logic       rst_n;
    logic       evt;
    logic [7:0] cnt;
  } model_t;

  model_t mA, mB;

  function automatic model_t modelReset();
    model_t m;
    m.n        = 0;
    m.raw_h    = '1;
    m.sync_h   = '1;
    m.stable   = 1'b1;
    m.last_low = 0;
    m.has_low  = 1'b0;
    m.rst_n    = 1'b0;
    m.evt      = 1'b0;
    m.cnt      = 8'd0;
    return m;
  endfunction

  // One clock edge of the model: the button level as seen s edges late, accepted
  // once d consecutive samples disagree; the reset is released once POR is over and
  // either no low level was ever seen since then or the level has been high for mr+1 edges.
  function automatic model_t modelStep(model_t m, logic raw, int s, int d, int p, int mr);
    logic seen;
    logic sync_pre;
    bit   flip;
    m.n++;
    seen     = m.stable;
    sync_pre = m.raw_h[5'(s - 1)];
    m.raw_h  = {m.raw_h[30:0], raw};
    m.sync_h = {m.sync_h[30:0], sync_pre};
    flip = 1'b1;
    for (int i = 0; i < d; i++) begin
      if (m.sync_h[5'(i)] == seen) flip = 1'b0;
    end
    if (flip) m.stable = ~seen;
    m.evt = 1'b0;
    if (m.n >= p && seen == 1'b0) begin
      if (m.rst_n) begin
        m.evt = 1'b1;
        m.cnt++;
      end
      m.has_low  = 1'b1;
      m.last_low = m.n;
    end
    m.rst_n = (m.n >= p) && (!m.has_low || (m.n - m.last_low >= mr + 1));
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic raw_main, input logic raw_fast, input int cycles);
    btn_n_raw  = raw_main;
    btn2_n_raw = raw_fast;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitRstN(input string name, input logic v, input int limit);
    int i;
    i = 0;
    while (rst_n_out !== v && i < limit) begin
      @(negedge clk);
      i++;
    end
    checkOutput(name, 8'(rst_n_out), 8'(v));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA = modelReset();
      mB = modelReset();
    end else begin
      mA = modelStep(mA, btn_n_raw, SYNC, DEB, POR, MINR);
      mB = modelStep(mB, btn2_n_raw, SYNC, F_DEB, POR, F_MINR);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model_rst_n",   8'(rst_n_out),   8'(mA.rst_n));
      checkOutput("model_led",     8'(led_active),  8'(mA.rst_n));
      checkOutput("model_event",   8'(btn_event),   8'(mA.evt));
      checkOutput("model_count",   press_count,     mA.cnt);
      checkOutput("model2_rst_n",  8'(rst2_n_out),  8'(mB.rst_n));
      checkOutput("model2_led",    8'(led2_active), 8'(mB.rst_n));
      checkOutput("model2_event",  8'(btn2_event),  8'(mB.evt));
      checkOutput("model2_count",  press2_count,    mB.cnt);
    end
  end

  initial begin
    $display("[TB] btn_reset_sequencer bench start");
    rst        = 1'b1;
    btn_n_raw  = 1'b1;
    btn2_n_raw = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rst_n", 8'(rst_n_out),  8'd0);
    checkOutput("reset_led",   8'(led_active), 8'd0);
    checkOutput("reset_event", 8'(btn_event),  8'd0);
    checkOutput("reset_count", press_count,    8'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b1, 15);
    checkOutput("por_hold_rst_n", 8'(rst_n_out),  8'd0);
    checkOutput("por_hold_led",   8'(led_active), 8'd0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("por_done_rst_n", 8'(rst_n_out),  8'd1);
    checkOutput("por_done_led",   8'(led_active), 8'd1);
    checkOutput("por_done_count", press_count,    8'd0);

    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("press_edge10_rst_n", 8'(rst_n_out), 8'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("press_edge11_rst_n", 8'(rst_n_out), 8'd0);
    checkOutput("press_edge11_event", 8'(btn_event), 8'd1);
    checkOutput("press_edge11_count", press_count,   8'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("press_edge12_event", 8'(btn_event), 8'd0);

    applyStimulus(1'b1, 1'b1, 14);
    checkOutput("release_edge14_rst_n", 8'(rst_n_out), 8'd0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("release_edge15_rst_n", 8'(rst_n_out),  8'd1);
    checkOutput("release_edge15_led",   8'(led_active), 8'd1);

    applyStimulus(1'b0, 1'b1, 7);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("glitch_rst_n", 8'(rst_n_out), 8'd1);
    checkOutput("glitch_count", press_count,   8'd1);

    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("fast_press_rst_n", 8'(rst2_n_out), 8'd0);
    checkOutput("fast_press_count", press2_count,   8'd1);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("fast_reentry_edge14_rst_n", 8'(rst2_n_out), 8'd0);
    applyStimulus(1'b1, 1'b1, 4);
    checkOutput("fast_reentry_edge18_rst_n", 8'(rst2_n_out), 8'd0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("fast_reentry_edge19_rst_n", 8'(rst2_n_out), 8'd1);
    checkOutput("fast_reentry_count",        press2_count,   8'd1);

    for (int k = 0; k < 255; k++) begin
      btn_n_raw = 1'b0;
      waitRstN("wrap_press_fall", 1'b0, 40);
      btn_n_raw = 1'b1;
      waitRstN("wrap_release_rise", 1'b1, 40);
    end
    checkOutput("wrap_count", press_count, 8'd0);

    btn_n_raw = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 16);
    checkOutput("held_por_rst_n", 8'(rst_n_out),  8'd0);
    checkOutput("held_por_led",   8'(led_active), 8'd0);
    checkOutput("held_por_event", 8'(btn_event),  8'd0);
    checkOutput("held_por_count", press_count,    8'd0);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 14);
    checkOutput("held_release_edge14_rst_n", 8'(rst_n_out), 8'd0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("held_release_edge15_rst_n", 8'(rst_n_out), 8'd1);
    checkOutput("held_release_count",        press_count,   8'd0);

    applyStimulus(1'b0, 1'b1, 12);
    checkOutput("midrst_press_count", press_count, 8'd1);
    applyStimulus(1'b1, 1'b1, 11);
    checkOutput("midrst_stretch_rst_n", 8'(rst_n_out), 8'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_async_rst_n", 8'(rst_n_out),  8'd0);
    checkOutput("midrst_async_led",   8'(led_active), 8'd0);
    checkOutput("midrst_async_event", 8'(btn_event),  8'd0);
    checkOutput("midrst_async_count", press_count,    8'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 15);
    checkOutput("midrst_por_edge15_rst_n", 8'(rst_n_out), 8'd0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midrst_por_edge16_rst_n", 8'(rst_n_out), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_reset_sequencer.md
Name: btn_reset_sequencer

Overview:
- Upstream stage of the iCEstick wrapper; generates the active-low reset for the TinyTapeout VGA core from the raw board button and PLL lock.
- Synchronises and debounces BTN_N, holds reset after PLL lock (power-on hold), and stretches every button reset to a guaranteed minimum width.
- Also drives the status LED and a press counter for bring-up.
- Runs entirely in the 25.175 MHz PLL clock domain.

Parameters:
- SYNC_STAGES, 2, number of flops in the button synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 251750, consecutive cycles a new button level must persist before it is accepted (~10 ms); must be >=1.
- POR_HOLD_CYCLES, 1024, cycles rst_n_out is held low after rst deasserts; must be >=1.
- MIN_RESET_CYCLES, 16, minimum cycles rst_n_out stays low after button release; must be >=1.

Ports:
- clk  in  1  25.175 MHz PLL output clock.
- rst  in  1  asynchronous, active-high reset; top level drives !pll_locked.
- btn_n_raw  in  1  raw board button, active low, asynchronous to clk.
- rst_n_out  out  1  registered active-low reset to the VGA core.
- led_active  out  1  registered; 1 only in S_RUN.
- btn_event  out  1  one-cycle pulse on each accepted press.
- press_count  out  8  accepted presses since rst, wrapping 255->0.

Behaviour:
- Reset values (asynchronous on rst=1):
  - Synchroniser flops = 1; btn_stable = 1; debounce counter = 0.
  - state = S_POR; all FSM counters = 0.
  - rst_n_out = 0; led_active = 0; btn_event = 0; press_count = 0.
- Synchroniser: btn_n_raw is shifted through SYNC_STAGES flops. btn_sync is the output of the last flop.
- Debounce:
  - When btn_sync == btn_stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and still mismatches, btn_stable <= btn_sync and the counter clears on that same edge.
  - A single agreeing sample restarts the count.
- FSM, evaluated on btn_stable as registered:
  - S_POR:
    - rst_n_out = 0; the hold counter increments every cycle.
    - When the count reaches POR_HOLD_CYCLES-1: go to S_RUN if btn_stable = 1, else to S_BTN. A press held through power-on does not count as an event.
  - S_RUN:
    - rst_n_out = 1; led_active = 1.
    - When btn_stable = 0: go to S_BTN, pulse btn_event, increment press_count.
  - S_BTN:
    - rst_n_out = 0.
    - When btn_stable = 1: go to S_STRETCH and clear the stretch counter.
  - S_STRETCH:
    - rst_n_out = 0.
    - If btn_stable = 0: go back to S_BTN. Re-entry is not a new event, and the stretch counter clears.
    - Otherwise, when the stretch counter reaches MIN_RESET_CYCLES-1: go to S_RUN.
- Outputs are registered from next-state logic, so each output changes on the same edge as the state register.
- Latency:
  - Raw press to rst_n_out falling: exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges, for a clean level change.
  - Stable release to rst_n_out rising: DEBOUNCE_CYCLES + MIN_RESET_CYCLES + SYNC_STAGES + 1 edges.
- Glitches: a raw glitch shorter than DEBOUNCE_CYCLES never changes btn_stable and never affects rst_n_out.
- rst mid-operation: every output immediately takes its reset value, and the sequence restarts at S_POR. The full POR hold is applied again.
- Counter widths: $clog2(param) bits, with a minimum of 1. Counters never exceed param-1.

Decomposition:
- Shared package vga_fpga_pkg holds:
  - state enum {S_POR, S_RUN, S_BTN, S_STRETCH}, 2-bit encoding.
  - Default parameter constants.
  - A CLK_HZ = 25_175_000 constant, used to derive DEBOUNCE_CYCLES.
- One sub-module, btn_debounce: the synchroniser plus the debounce counter, outputting btn_stable. It is reusable for future buttons.
- The FSM, press counter and output registers stay in btn_reset_sequencer.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, POR_HOLD_CYCLES=16, MIN_RESET_CYCLES=4.
1. Power-on: hold rst for 3 cycles, then release with btn_n_raw=1 -> rst_n_out=0 and led_active=0 for 16 cycles; on edge 16 after release, rst_n_out=1 and led_active=1; press_count=0.
2. Clean press: in S_RUN, drive btn_n_raw=0 -> rst_n_out falls exactly 11 edges later; btn_event high for exactly 1 cycle; press_count=1.
3. Glitch rejection: in S_RUN, pulse btn_n_raw=0 for 7 cycles, then return to 1 -> rst_n_out stays 1; btn_event never asserts; press_count unchanged.
4. Release and stretch: after press, release btn_n_raw=1 -> rst_n_out rises exactly 8+4+2+1=15 edges after release. Re-pressing during S_STRETCH (a press lasting >=8 cycles) -> returns to S_BTN, and press_count does not increment.
5. Press held through POR: btn_n_raw=0 at rst release -> after 16 cycles the FSM enters S_BTN, btn_event stays 0, and rst_n_out stays 0 until release plus stretch.
6. Mid-operation reset and wrap: 256 accepted presses -> press_count wraps to 0. Asserting rst during S_STRETCH -> all outputs reset asynchronously within the same cycle, and the full 16-cycle POR hold is repeated.
